morse_letter_decoder: RTL and testbench

MORSE_LETTER_DECODER -- requirements
Module: morse_letter_decoder

---
 rtl/morse_letter_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_morse_letter_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/morse_letter_decoder.sv
// -----------------------------------------------------------------------------
// morse_letter_decoder
//
// Decodes a keyed Morse line into one of the letters A..H. A unit counter
// divides the clock into Morse time units. The line is looked at only once per
// unit, on the "strobe". Marks of 1-2 units are dots and marks of 3-4 units
// are dashes. A letter ends after 3 units of silence.
//
// Ports
//   clock   in   1  single clock, rising edge
//   areset  in   1  asynchronous, active-high reset
//   enable  in   1  decoder enable; low aborts any letter in progress
//   din     in   1  keyed line (1 = tone on), already synchronous to clock
//   letter  out  3  last decoded letter: A=0 .. H=7
//   valid   out  1  one-cycle pulse when letter is updated
//   error   out  1  one-cycle pulse when a letter ended undecodable
//   busy    out  1  high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module morse_letter_decoder #(
  parameter int UNIT_CYCLES = 10
) (
  input  logic       clock,
  input  logic       areset,
  input  logic       enable,
  input  logic       din,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  localparam logic [9:0] UNIT_LAST = 10'(UNIT_CYCLES - 1);

  state_t     state_r;
  logic [9:0] unit_cnt_r;
  logic [2:0] mark_len_r;
  logic [1:0] space_len_r;
  logic [2:0] sym_cnt_r;
  logic [3:0] sym_bits_r;
  logic       err_flag_r;
  logic [2:0] letter_r;
  logic       valid_r;
  logic       error_r;
  logic       busy_r;

  logic       strobe_s;
  logic       is_dash_s;
  logic       bad_mark_s;
  logic [3:0] sym_bits_next_s;
  logic [2:0] sym_cnt_next_s;
  logic       append_err_s;
  logic [3:0] decode_s;

  // Map (symbol count, symbol bits) to {hit, letter code}. Bits hold the
  // symbols oldest-first from the MSB side, with dash=1 and dot=0.
  function automatic logic [3:0] decode_letter(input logic [2:0] cnt,
                                               input logic [3:0] bits);
    logic [3:0] res;
    case ({cnt, bits})
      7'b010_0001: res = {1'b1, 3'd0};  // A .-
      7'b100_1000: res = {1'b1, 3'd1};  // B -...
      7'b100_1010: res = {1'b1, 3'd2};  // C -.-.
      7'b011_0100: res = {1'b1, 3'd3};  // D -..
      7'b001_0000: res = {1'b1, 3'd4};  // E .
      7'b100_0010: res = {1'b1, 3'd5};  // F ..-.
      7'b011_0110: res = {1'b1, 3'd6};  // G --.
      7'b100_0000: res = {1'b1, 3'd7};  // H ....
      default:     res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  // The unit counter sits at 0 in IDLE, so a strobe can only occur in MARK/SPACE.
  assign strobe_s = (unit_cnt_r == UNIT_LAST);

  // Classify the finished mark and form the symbol register after the append.
  always_comb begin
    is_dash_s       = (mark_len_r >= 3'd3);
    bad_mark_s      = (mark_len_r >= 3'd5);
    sym_bits_next_s = {sym_bits_r[2:0], is_dash_s};
    if (sym_cnt_r >= 3'd5) begin
      sym_cnt_next_s = 3'd5;
    end else begin
      sym_cnt_next_s = sym_cnt_r + 3'd1;
    end
    // Appending when four symbols are already stored makes a fifth symbol.
    if (sym_cnt_r >= 3'd4) begin
      append_err_s = 1'b1;
    end else begin
      append_err_s = 1'b0;
    end
    decode_s = decode_letter(sym_cnt_r, sym_bits_r);
  end

  // Decoder FSM with registered letter, pulse and busy outputs.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_r     <= ST_IDLE;
      unit_cnt_r  <= 10'd0;
      mark_len_r  <= 3'd0;
      space_len_r <= 2'd0;
      sym_cnt_r   <= 3'd0;
      sym_bits_r  <= 4'd0;
      err_flag_r  <= 1'b0;
      letter_r    <= 3'd0;
      valid_r     <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      error_r <= 1'b0;
      if (!enable) begin
        // Abort: drop everything about the current letter but keep letter_r.
        state_r     <= ST_IDLE;
        unit_cnt_r  <= 10'd0;
        mark_len_r  <= 3'd0;
        space_len_r <= 2'd0;
        sym_cnt_r   <= 3'd0;
        sym_bits_r  <= 4'd0;
        err_flag_r  <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            unit_cnt_r <= 10'd0;
            if (din) begin
              state_r     <= ST_MARK;
              busy_r      <= 1'b1;
              mark_len_r  <= 3'd1;
              space_len_r <= 2'd0;
              sym_cnt_r   <= 3'd0;
              sym_bits_r  <= 4'd0;
              err_flag_r  <= 1'b0;
            end else begin
              busy_r <= 1'b0;
            end
          end

          ST_MARK: begin
            unit_cnt_r <= strobe_s ? 10'd0 : unit_cnt_r + 10'd1;
            if (strobe_s) begin
              if (din) begin
                if (mark_len_r != 3'd7) begin
                  mark_len_r <= mark_len_r + 3'd1;
                end else begin
                  mark_len_r <= mark_len_r;
                end
              end else begin
                sym_bits_r  <= sym_bits_next_s;
                sym_cnt_r   <= sym_cnt_next_s;
                err_flag_r  <= err_flag_r | bad_mark_s | append_err_s;
                state_r     <= ST_SPACE;
                space_len_r <= 2'd1;
              end
            end else begin
              mark_len_r <= mark_len_r;
            end
          end

          ST_SPACE: begin
            unit_cnt_r <= strobe_s ? 10'd0 : unit_cnt_r + 10'd1;
            if (strobe_s) begin
              if (din) begin
                state_r    <= ST_MARK;
                mark_len_r <= 3'd1;
              end else if (space_len_r == 2'd2) begin
                // Third silent unit: the letter is complete.
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                space_len_r <= 2'd0;
                mark_len_r  <= 3'd0;
                sym_cnt_r   <= 3'd0;
                sym_bits_r  <= 4'd0;
                err_flag_r  <= 1'b0;
                if (decode_s[3] && !err_flag_r) begin
                  letter_r <= decode_s[2:0];
                  valid_r  <= 1'b1;
                end else begin
                  error_r <= 1'b1;
                end
              end else begin
                space_len_r <= space_len_r + 2'd1;
              end
            end else begin
              space_len_r <= space_len_r;
            end
          end

          default: begin
            state_r    <= ST_IDLE;
            unit_cnt_r <= 10'd0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign letter = letter_r;
  assign valid  = valid_r;
  assign error  = error_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_morse_letter_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_letter_decoder
//
// Directed Morse patterns with hand-computed results. Each pattern pushes its
// expected outcome into a queue, and a monitor pops one entry whenever the
// decoder pulses valid or error.
// -----------------------------------------------------------------------------
module tb_morse_letter_decoder;

  localparam int U = 10;

  logic       clock = 1'b0;
  logic       areset;
  logic       enable;
  logic       din;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_err;
    logic [2:0] code;
  } exp_t;

  exp_t exp_q[$];

  morse_letter_decoder #(.UNIT_CYCLES(U)) dut (
    .clock  (clock),
    .areset (areset),
    .enable (enable),
    .din    (din),
    .letter (letter),
    .valid  (valid),
    .error  (error),
    .busy   (busy)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_pulse(input logic is_err, input logic [2:0] code);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  // Hold din at v for n clock cycles; changes land on falling edges.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clock);
  endtask

  // Key a pattern of '.' and '-' with 1-unit gaps, then 3 units of silence.
  task automatic send(input string pat);
    byte c;
    for (int i = 0; i < pat.len(); i++) begin
      c = pat[i];
      hold(1'b1, (c == 8'h2D) ? 3 * U : U);
      if (i != pat.len() - 1) hold(1'b0, U);
    end
    hold(1'b0, 3 * U);
  endtask

  // Scoreboard monitor: compare every pulse with the oldest expected outcome.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!areset && (valid || error)) begin
      check("valid_error_exclusive", {31'd0, valid && error}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b letter=%0d, expected no pulse",
                 valid, error, letter);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_error", {31'd0, error}, {31'd0, e.is_err});
        check("letter_code", {29'd0, letter}, {29'd0, e.code});
      end
    end
  end

  initial begin
    areset = 1'b1;
    enable = 1'b1;
    din    = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_letter", {29'd0, letter}, 32'd0);
    check("reset_valid",  {31'd0, valid},  32'd0);
    check("reset_error",  {31'd0, error},  32'd0);
    check("reset_busy",   {31'd0, busy},   32'd0);
    areset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // E: 10 cycles high, 40 low
    expect_pulse(1'b0, 3'd4);
    hold(1'b1, 10);
    hold(1'b0, 40);
    check("busy_after_E", {31'd0, busy}, 32'd0);

    expect_pulse(1'b0, 3'd0); send(".-");   // A
    expect_pulse(1'b1, 3'd0); send("-.");   // N: not supported
    expect_pulse(1'b0, 3'd1); send("-..."); // B
    expect_pulse(1'b0, 3'd2); send("-.-."); // C
    expect_pulse(1'b0, 3'd3); send("-..");  // D
    expect_pulse(1'b0, 3'd5); send("..-."); // F
    expect_pulse(1'b0, 3'd6); send("--.");  // G
    expect_pulse(1'b0, 3'd7); send("....");  // H
    expect_pulse(1'b1, 3'd7); send("....."); // five symbols

    // Mark of 6 units
    expect_pulse(1'b1, 3'd7);
    hold(1'b1, 6 * U);
    hold(1'b0, 3 * U);

    // D with a 3-cycle glitch between strobes in the first gap
    expect_pulse(1'b0, 3'd3);
    hold(1'b1, 3 * U);
    hold(1'b0, 3);
    hold(1'b1, 3);
    hold(1'b0, U - 6);
    hold(1'b1, U);
    hold(1'b0, U);
    hold(1'b1, U);
    hold(1'b0, 3 * U);

    // Abort a B after its dash: no pulse at all for it
    hold(1'b1, 3 * U);
    hold(1'b0, 5);
    enable = 1'b0;
    @(negedge clock);
    check("busy_after_enable_drop", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    hold(1'b0, 4 * U);
    check("letter_after_abort", {29'd0, letter}, 32'd3);

    // Recovery
    expect_pulse(1'b0, 3'd4); send(".");

    // Asynchronous reset in the middle of a mark
    hold(1'b1, 15);
    #1 areset = 1'b1;
    #2;
    check("async_letter", {29'd0, letter}, 32'd0);
    check("async_valid",  {31'd0, valid},  32'd0);
    check("async_error",  {31'd0, error},  32'd0);
    check("async_busy",   {31'd0, busy},   32'd0);
    din = 1'b0;
    @(negedge clock);
    areset = 1'b0;
    @(negedge clock);
    expect_pulse(1'b0, 3'd6); send("--.");  // G after reset

    repeat (20) @(negedge clock);
    check("queue_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
